riscv_lsu: RTL and testbench
============================

// Module: riscv_lsu
// PURPOSE
//  Parametrised load/store unit between the core datapath and data memory. Replaces the raw single-cycle
//  WriteEnable/ReadEnable/Address/WRData/RDData path with a valid/ready request port, wait-state memory
//  handshake, byte-lane enables, load sign/zero extension and a bus-timeout fault. Sits between DataPath and data RAM.
// PARAMETERS
//  DATA_WIDTH      32   memory/register width; 32 or 64 only (64 enables LD/SD/LWU)
//  ADDR_WIDTH      9    byte address width
//  TIMEOUT_CYCLES  255  REQ-state cycles without mem_ack before fault; 1..(2^16-1)
// PORTS
//  clk         in   1             clock, all logic on rising edge
//  rst         in   1             synchronous reset, active-low
//  req_valid   in   1             access request
//  req_ready   out  1             LSU idle, request accepted when valid&ready
//  req_write   in   1             1=store, 0=load
//  req_funct3  in   3             RISC-V size/sign code
//  req_addr    in   ADDR_WIDTH    byte address
//  req_wdata   in   DATA_WIDTH    store data, right-aligned
//  req_rd      in   5             load destination register tag
//  resp_valid  out  1             one-cycle response pulse (loads and stores)
//  resp_rdata  out  DATA_WIDTH    extended load data; 0 for stores/faults
//  resp_rd     out  5             echo of req_rd
//  resp_fault  out  1             illegal funct3, timeout or misalign (see CONFIGURATION)
//  mem_rd_en   out  1             memory read strobe
//  mem_wr_en   out  1             memory write strobe
//  mem_addr    out  ADDR_WIDTH    word-aligned byte address (low log2(DATA_WIDTH/8) bits = 0)
//  mem_be      out  DATA_WIDTH/8  byte-lane enables
//  mem_wdata   out  DATA_WIDTH    lane-shifted store data
//  mem_rdata   in   DATA_WIDTH    read data, valid when mem_ack=1
//  mem_ack     in   1             memory completion
// BEHAVIOUR
//  - Reset (rst=0 at edge): state IDLE, req_ready=1 after reset, all other outputs 0, timeout counter 0.
//  - FSM IDLE -> REQ on accept; REQ -> RESP on mem_ack or timeout; RESP -> IDLE unconditionally.
//    IDLE -> RESP directly on accept with illegal funct3 (fault, no memory strobes).
//  - req_ready = (state==IDLE). Request fields are registered at the accept edge; inputs are ignored otherwise.
//  - REQ: exactly one of mem_rd_en/mem_wr_en high; mem_addr/be/wdata held stable until mem_ack seen.
//  - mem_ack sampled only in REQ; mem_rdata captured at the same edge. Zero-wait latency: accept edge N,
//    strobes in cycle N+1, resp_valid in cycle N+2. Each wait cycle adds one.
//  - funct3: 000 B, 001 H, 010 W, 011 D(64 only), 100 BU, 101 HU, 110 WU(64 only, loads).
//    Stores with 1xx, and D/WU when DATA_WIDTH=32, are illegal.
//  - Offset = addr low bits. mem_be = size mask << offset. mem_wdata = req_wdata << (8*offset).
//    Load data = mem_rdata >> (8*offset), truncated to size, sign- or zero-extended to DATA_WIDTH.
//  - Timeout: counter clears on entering REQ and increments each REQ cycle without ack. On reaching
//    TIMEOUT_CYCLES: strobes drop, RESP with resp_fault=1, resp_rdata=0. A late ack in IDLE is ignored.
//  - resp_valid is high for exactly one cycle per accepted request, with no backpressure; resp_* are 0 when resp_valid=0.
//  - Reset mid-operation: strobes and resp_valid are 0 from the next edge; the in-flight request is
//    dropped without a response.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: access not naturally aligned (H odd, W offset!=0 mod 4, D offset!=0)
//    -> no memory strobes, IDLE->RESP, resp_fault=1, resp_rdata=0.
//  Undefined: offset low bits below access size are forced to 0 (LW @0x011 behaves as @0x010); no fault.
// TESTING
//  1. LW 0x010, mem_rdata=0xDEADBEEF, ack in first REQ cycle -> mem_be=1111, resp_rdata=0xDEADBEEF, resp_valid at accept+2.
//  2. LB 0x013, mem_rdata=0x80000000 -> resp_rdata=0xFFFFFF80; LBU same -> 0x00000080; resp_rd echoed.
//  3. SH 0x012, wdata=0x0000ABCD -> mem_addr=0x010, mem_be=1100, mem_wdata=0xABCD0000, resp_rdata=0.
//  4. mem_ack delayed 3 cycles -> strobes/addr stable for 4 cycles, single resp_valid, req_ready low throughout.
//  5. No ack, TIMEOUT_CYCLES=4 -> strobes drop after 4 REQ cycles, resp_fault=1; then rst=0 mid-REQ -> no resp, outputs 0.
//  6. LW 0x011: with LSU_MISALIGN_TRAP_EN -> fault, no strobes; without -> access 0x010, be=1111; funct3=111 -> fault.

Source files
------------

// File: rtl/riscv_lsu.sv
// riscv_lsu: valid/ready load/store unit with byte-lane steering, load extension and bus timeout.
// Define LSU_MISALIGN_TRAP_EN to fault on misaligned accesses instead of aligning them down.
module riscv_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 9,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [2:0]              req_funct3,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [4:0]              req_rd,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic [4:0]              resp_rd,
    output logic                    resp_fault,
    output logic                    mem_rd_en,
    output logic                    mem_wr_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ack
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int OW = $clog2(NB);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] { IDLE, REQ, RESP } state_t;
    state_t state, state_nx;

    logic [1:0]            size;
    logic                  legal, trap, tmo;
    logic [OW-1:0]         off_raw, off, amask;
    logic [7:0]            bmask;

    logic                  write_q, fault_q;
    logic [2:0]            f3_q;
    logic [OW-1:0]         off_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [NB-1:0]         be_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q, shifted, ld;
    logic [4:0]            rd_q;
    logic [15:0]           cnt;

    always_comb begin
        size  = 2'd0;
        legal = 1'b0;
        unique case (req_funct3)
            3'b000: begin size = 2'd0; legal = 1'b1; end
            3'b001: begin size = 2'd1; legal = 1'b1; end
            3'b010: begin size = 2'd2; legal = 1'b1; end
            3'b011: begin size = 2'd3; legal = (DATA_WIDTH == 64); end
            3'b100: begin size = 2'd0; legal = !req_write; end
            3'b101: begin size = 2'd1; legal = !req_write; end
            3'b110: begin size = 2'd2; legal = !req_write && (DATA_WIDTH == 64); end
            default: begin size = 2'd0; legal = 1'b0; end
        endcase
        bmask = 8'h01;
        unique case (size)
            2'd0: bmask = 8'h01;
            2'd1: bmask = 8'h03;
            2'd2: bmask = 8'h0f;
            default: bmask = 8'hff;
        endcase
        amask   = OW'((8'd1 << size) - 8'd1);
        off_raw = req_addr[OW-1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        off  = off_raw;
        trap = |(off_raw & amask);
`else
        // Sub-size offset bits are dropped, so misaligned accesses land on the aligned slot
        off  = off_raw & ~amask;
        trap = 1'b0;
`endif
    end

    assign tmo = (cnt == TMO_LAST);

    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        ld      = shifted;
        unique case (f3_q)
            3'b000: ld = DATA_WIDTH'($signed(shifted[7:0]));
            3'b001: ld = DATA_WIDTH'($signed(shifted[15:0]));
            3'b010: ld = DATA_WIDTH'($signed(shifted[31:0]));
            3'b100: ld = DATA_WIDTH'(shifted[7:0]);
            3'b101: ld = DATA_WIDTH'(shifted[15:0]);
            3'b110: ld = DATA_WIDTH'(shifted[31:0]);
            default: ld = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (req_valid) state_nx = (legal && !trap) ? REQ : RESP;
            REQ:  if (mem_ack || tmo) state_nx = RESP;
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            write_q <= 1'b0;
            fault_q <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= '0;
            cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: if (req_valid) begin
                    write_q <= req_write;
                    f3_q    <= req_funct3;
                    off_q   <= off;
                    addr_q  <= {req_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
                    be_q    <= bmask[NB-1:0] << off;
                    wdata_q <= req_wdata << {off, 3'b000};
                    rd_q    <= req_rd;
                    cnt     <= '0;
                    fault_q <= !legal || trap;
                    rdata_q <= '0;
                end
                REQ: begin
                    // Ack wins over timeout when both land on the same edge
                    if (mem_ack)  rdata_q <= write_q ? '0 : ld;
                    else if (tmo) fault_q <= 1'b1;
                    else          cnt     <= cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready  = (state == IDLE);
        mem_rd_en  = (state == REQ) && !write_q;
        mem_wr_en  = (state == REQ) && write_q;
        mem_addr   = (state == REQ) ? addr_q : '0;
        mem_be     = (state == REQ) ? be_q : '0;
        mem_wdata  = (state == REQ) ? wdata_q : '0;
        resp_valid = (state == RESP);
        resp_rdata = (state == RESP) ? rdata_q : '0;
        resp_rd    = (state == RESP) ? rd_q : '0;
        resp_fault = (state == RESP) && fault_q;
    end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed and randomized checks of riscv_lsu against a byte-level memory model.
// Follows LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_riscv_lsu;
    localparam int DW  = 32;
    localparam int AW  = 9;
    localparam int TMO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, req_valid, req_ready, req_write;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata, resp_rdata, mem_wdata, mem_rdata;
    logic [4:0]    req_rd, resp_rd;
    logic          resp_valid, resp_fault, mem_rd_en, mem_wr_en, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;

    riscv_lsu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
        .resp_fault(resp_fault),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [128];
    logic [31:0] last_rdata;
    logic        last_fault;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_strb"}, {mem_rd_en, mem_wr_en, mem_addr, mem_be, resp_valid, resp_fault}, 0);
        check({tag, "_data"}, {mem_wdata, resp_rdata}, 0);
        check({tag, "_rd"}, resp_rd, 0);
    endtask

    function automatic void model(input logic wr, input logic [2:0] f3, input logic [8:0] addr,
                                  input logic [31:0] wd, output logic fault,
                                  output logic [8:0] maddr, output logic [3:0] be,
                                  output logic [31:0] mwd, output int eff, output int nb);
        int off;
        bit legal;
        nb    = 1 << f3[1:0];
        legal = (f3 <= 3'd2) || (!wr && (f3 == 3'd4 || f3 == 3'd5));
        off   = int'(addr) % 4;
`ifdef LSU_MISALIGN_TRAP_EN
        fault = !legal || (off % nb != 0);
        eff   = off;
`else
        fault = !legal;
        eff   = off - off % nb;
`endif
        maddr = addr - 9'(off);
        be    = 4'(((1 << nb) - 1) << eff);
        mwd   = wd << (8 * eff);
    endfunction

    function automatic logic [31:0] ldval(input logic [31:0] word, input int eff, input int nb,
                                          input bit uns);
        longint v;
        v = longint'(word >> (8 * eff)) & ((longint'(1) << (8 * nb)) - 1);
        if (!uns && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
        return 32'(v);
    endfunction

    task automatic txn(input logic wr, input logic [2:0] f3, input logic [8:0] addr,
                       input logic [31:0] wd, input int waits);
        logic fault, timed;
        logic [8:0] maddr;
        logic [3:0] be;
        logic [31:0] mwd, word, exp_rd;
        logic [4:0] rd;
        int eff, nb;
        model(wr, f3, addr, wd, fault, maddr, be, mwd, eff, nb);
        timed  = !fault && (waits >= TMO);
        rd     = 5'($urandom);
        word   = mem[maddr[8:2]];
        exp_rd = (wr || fault || timed) ? 32'd0 : ldval(word, eff, nb, f3[2]);
        check("ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_rd     = rd;
        step();
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = 9'($urandom);
        req_wdata  = $urandom;
        req_rd     = 5'($urandom);
        if (!fault) begin
            for (int i = 0; i < TMO; i++) begin
                check("rd_en", mem_rd_en, !wr);
                check("wr_en", mem_wr_en, wr);
                check("addr", mem_addr, maddr);
                check("be", mem_be, be);
                if (wr) check("wdata", mem_wdata, mwd);
                check("busy", {req_ready, resp_valid, resp_fault, resp_rdata, resp_rd}, 0);
                mem_ack   = (i == waits);
                mem_rdata = mem_ack ? word : $urandom;
                step();
                if (i == waits) break;
            end
            mem_ack = 1'b0;
        end
        check("resp_valid", resp_valid, 1);
        check("resp_fault", resp_fault, fault || timed);
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_rd", resp_rd, rd);
        check("resp_strb", {mem_rd_en, mem_wr_en, req_ready}, 0);
        if (wr && !fault && !timed)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[maddr[8:2]][8*b +: 8] = mwd[8*b +: 8];
        last_rdata = resp_rdata;
        last_fault = resp_fault;
        step();
        check("resp_pulse", {resp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0;
        req_wdata = '0; req_rd = '0; mem_rdata = '0; mem_ack = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        step();
        step();
        check("rst_ready", req_ready, 1);
        check_quiet("rst");
        rst = 1'b1;
        step();

        mem[4] = 32'hdeadbeef;
        txn(1'b0, 3'b010, 9'h010, 32'h0, 0);
        check("t1_lw", last_rdata, 32'hdeadbeef);

        mem[4] = 32'h80000000;
        txn(1'b0, 3'b000, 9'h013, 32'h0, 0);
        check("t2_lb", last_rdata, 32'hffffff80);
        txn(1'b0, 3'b100, 9'h013, 32'h0, 1);
        check("t2_lbu", last_rdata, 32'h00000080);

        txn(1'b1, 3'b001, 9'h012, 32'h0000abcd, 0);
        check("t3_sh_rdata", last_rdata, 32'h0);
        txn(1'b0, 3'b010, 9'h010, 32'h0, 3);
        check("t4_lw_after_sh", last_rdata, 32'habcd0000);

        txn(1'b0, 3'b010, 9'h010, 32'h0, TMO);
        check("t5_timeout", last_fault, 1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("late_ack", {req_ready, resp_valid}, 2'b10);

        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 9'h020;
        step();
        req_valid = 1'b0;
        check("mid_busy", mem_rd_en, 1);
        step();
        rst = 1'b0;
        step();
        check("mid_rst_ready", req_ready, 1);
        check_quiet("mid_rst");
        rst = 1'b1;
        step();
        check("mid_rst_noresp", {resp_valid, req_ready}, 2'b01);
        step();
        check("mid_rst_noresp2", {resp_valid, req_ready}, 2'b01);

        txn(1'b0, 3'b010, 9'h011, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("t6_misalign", {last_fault, last_rdata}, {1'b1, 32'h0});
`else
        check("t6_misalign", {last_fault, last_rdata}, {1'b0, 32'habcd0000});
`endif
        txn(1'b0, 3'b111, 9'h010, 32'h0, 0);
        check("t6_f3_111", last_fault, 1);
        txn(1'b1, 3'b100, 9'h010, 32'h0, 0);
        check("st_unsigned", last_fault, 1);

        for (int n = 0; n < 200; n++) begin
            int w;
            w = ($urandom % 8 == 0) ? TMO : int'($urandom % TMO);
            txn(1'($urandom), 3'($urandom), 9'($urandom), $urandom, w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
